median_stream_ctrl: RTL and testbench

MEDIAN_STREAM_CTRL -- requirements
Module: median_stream_ctrl

---
 rtl/median_stream_ctrl.sv | 129 ++++++++++++
 tb/tb_median_stream_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_stream_ctrl.sv
// Streaming median controller: a 10-entry sliding window feeds an external sort network, with one result every STRIDE accepts once the window is full.
// Optional feature macro: MEDIAN_AVG_EN adds the averaged median on out_avg; when it is undefined, out_avg is tied to 0.
module median_stream_ctrl #(
    parameter int STRIDE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] net_data_0,
    output logic [31:0] net_data_1,
    output logic [31:0] net_data_2,
    output logic [31:0] net_data_3,
    output logic [31:0] net_data_4,
    output logic [31:0] net_data_5,
    output logic [31:0] net_data_6,
    output logic [31:0] net_data_7,
    output logic [31:0] net_data_8,
    output logic [31:0] net_data_9,
    input  logic [31:0] net_sort_0,
    input  logic [31:0] net_sort_1,
    input  logic [31:0] net_sort_2,
    input  logic [31:0] net_sort_3,
    input  logic [31:0] net_sort_4,
    input  logic [31:0] net_sort_5,
    input  logic [31:0] net_sort_6,
    input  logic [31:0] net_sort_7,
    input  logic [31:0] net_sort_8,
    input  logic [31:0] net_sort_9,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_lo,
    output logic [31:0] out_hi,
    output logic [31:0] out_avg,
    output logic [3:0]  fill_cnt
);

    // Handshake: a transfer happens only on a rising edge where valid && ready are both high;
    // valid never waits for ready, and the payload holds until the transfer occurs.
    typedef enum logic {RUN, EVAL} state_t;

    state_t      state, state_nxt;
    logic [31:0] win [10];
    logic [3:0]  stride_cnt;
    logic [3:0]  fill_inc;
    logic        accept;
    logic        fire_eval;
    logic        capture;
    logic        unused_sort;

    // Only the two middle network outputs are needed.
    assign unused_sort = ^{net_sort_0, net_sort_1, net_sort_2, net_sort_3,
                           net_sort_6, net_sort_7, net_sort_8, net_sort_9};

    always_comb begin
        in_ready  = (state == RUN) && (!out_valid || out_ready);
        accept    = in_valid && in_ready && !flush;
        fill_inc  = (fill_cnt == 4'd10) ? 4'd10 : fill_cnt + 4'd1;
        fire_eval = accept && (fill_inc == 4'd10) && (stride_cnt == 4'(STRIDE - 1));
        capture   = (state == EVAL) && !flush;
        state_nxt = state;
        case (state)
            RUN:     if (fire_eval) state_nxt = EVAL;
            EVAL:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // Unfilled slots stay zero because only zeros are ever shifted past fill_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 10; k++) win[k] <= '0;
            fill_cnt   <= '0;
            stride_cnt <= '0;
        end else if (flush) begin
            for (int k = 0; k < 10; k++) win[k] <= '0;
            fill_cnt   <= '0;
            stride_cnt <= '0;
        end else if (accept) begin
            for (int k = 9; k > 0; k--) win[k] <= win[k-1];
            win[0]   <= in_data;
            fill_cnt <= fill_inc;
            if (fill_inc == 4'd10) stride_cnt <= fire_eval ? 4'd0 : stride_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_lo    <= '0;
            out_hi    <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (capture) begin
                out_valid <= 1'b1;
                out_lo    <= net_sort_4;
                out_hi    <= net_sort_5;
            end
        end
    end

`ifdef MEDIAN_AVG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          out_avg <= '0;
        else if (capture) out_avg <= 32'(({1'b0, net_sort_4} + {1'b0, net_sort_5}) >> 1);
    end
`else
    assign out_avg = '0;
`endif

    assign net_data_0 = win[0];
    assign net_data_1 = win[1];
    assign net_data_2 = win[2];
    assign net_data_3 = win[3];
    assign net_data_4 = win[4];
    assign net_data_5 = win[5];
    assign net_data_6 = win[6];
    assign net_data_7 = win[7];
    assign net_data_8 = win[8];
    assign net_data_9 = win[9];

endmodule

// File: tb/tb_median_stream_ctrl.sv
// Bench for median_stream_ctrl: STRIDE=1 and STRIDE=3 instances share one stimulus stream,
// each checked every cycle against an array/queue-sort reference model.
module tb_median_stream_ctrl;

    typedef logic [31:0] arr10_t [10];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        rdy1, ov1, rdy3, ov3;
    logic [31:0] lo1, hi1, avg1, lo3, hi3, avg3;
    logic [3:0]  fill1, fill3;
    arr10_t      nd0, nd1, ns0, ns1;

    int total = 0;
    int bad = 0;

    logic [31:0] m_win [2][10];
    int          m_fill [2];
    int          m_scnt [2];
    bit          m_eval [2];
    bit          m_ov [2];
    logic [31:0] m_lo [2];
    logic [31:0] m_hi [2];
    logic [31:0] m_avg [2];
    int          m_stride [2] = '{1, 3};
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    // Stand-in for the external combinational sort network.
    function automatic arr10_t sort10(input arr10_t a);
        arr10_t r;
        logic [31:0] t;
        r = a;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    always_comb ns0 = sort10(nd0);
    always_comb ns1 = sort10(nd1);

    median_stream_ctrl #(.STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .net_data_0(nd0[0]), .net_data_1(nd0[1]), .net_data_2(nd0[2]), .net_data_3(nd0[3]), .net_data_4(nd0[4]),
        .net_data_5(nd0[5]), .net_data_6(nd0[6]), .net_data_7(nd0[7]), .net_data_8(nd0[8]), .net_data_9(nd0[9]),
        .net_sort_0(ns0[0]), .net_sort_1(ns0[1]), .net_sort_2(ns0[2]), .net_sort_3(ns0[3]), .net_sort_4(ns0[4]),
        .net_sort_5(ns0[5]), .net_sort_6(ns0[6]), .net_sort_7(ns0[7]), .net_sort_8(ns0[8]), .net_sort_9(ns0[9]),
        .out_valid(ov1), .out_ready(out_ready), .out_lo(lo1), .out_hi(hi1), .out_avg(avg1), .fill_cnt(fill1)
    );

    median_stream_ctrl #(.STRIDE(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
        .net_data_0(nd1[0]), .net_data_1(nd1[1]), .net_data_2(nd1[2]), .net_data_3(nd1[3]), .net_data_4(nd1[4]),
        .net_data_5(nd1[5]), .net_data_6(nd1[6]), .net_data_7(nd1[7]), .net_data_8(nd1[8]), .net_data_9(nd1[9]),
        .net_sort_0(ns1[0]), .net_sort_1(ns1[1]), .net_sort_2(ns1[2]), .net_sort_3(ns1[3]), .net_sort_4(ns1[4]),
        .net_sort_5(ns1[5]), .net_sort_6(ns1[6]), .net_sort_7(ns1[7]), .net_sort_8(ns1[8]), .net_sort_9(ns1[9]),
        .out_valid(ov3), .out_ready(out_ready), .out_lo(lo3), .out_hi(hi3), .out_avg(avg3), .fill_cnt(fill3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] avg_of(input logic [31:0] a, input logic [31:0] b);
`ifdef MEDIAN_AVG_EN
        logic [63:0] s;
        s = ({32'd0, a} + {32'd0, b}) / 2;
        return s[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 10; k++) m_win[m][k] = '0;
            m_fill[m] = 0; m_scnt[m] = 0; m_eval[m] = 0; m_ov[m] = 0;
            m_lo[m] = '0; m_hi[m] = '0; m_avg[m] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input int m, input bit fl, input bit iv, input logic [31:0] id, input bit ordy);
        bit rdy, acc;
        logic [31:0] q [$];
        rdy = !m_eval[m] && (!m_ov[m] || ordy);
        acc = iv && rdy && !fl;
        if (m_ov[m] && ordy) m_ov[m] = 0;
        if (m_eval[m]) begin
            if (!fl) begin
                for (int k = 0; k < 10; k++) q.push_back(m_win[m][k]);
                q.sort();
                m_lo[m] = q[4]; m_hi[m] = q[5]; m_avg[m] = avg_of(q[4], q[5]);
                m_ov[m] = 1;
                if (m == 0) exp_q.push_back({q[5], q[4]});
            end
            m_eval[m] = 0;
        end
        if (fl) begin
            for (int k = 0; k < 10; k++) m_win[m][k] = '0;
            m_fill[m] = 0; m_scnt[m] = 0; m_eval[m] = 0;
        end else if (acc) begin
            for (int k = 9; k > 0; k--) m_win[m][k] = m_win[m][k-1];
            m_win[m][0] = id;
            if (m_fill[m] < 10) m_fill[m]++;
            if (m_fill[m] == 10) begin
                m_scnt[m]++;
                if (m_scnt[m] == m_stride[m]) begin
                    m_scnt[m] = 0;
                    m_eval[m] = 1;
                end
            end
        end
    endtask

    task automatic chk_all(input int m);
        bit exp_rdy;
        exp_rdy = !m_eval[m] && (!m_ov[m] || out_ready);
        chk($sformatf("s%0d_in_ready", m), 32'(m ? rdy3 : rdy1), 32'(exp_rdy));
        chk($sformatf("s%0d_out_valid", m), 32'(m ? ov3 : ov1), 32'(m_ov[m]));
        chk($sformatf("s%0d_out_lo", m), m ? lo3 : lo1, m_lo[m]);
        chk($sformatf("s%0d_out_hi", m), m ? hi3 : hi1, m_hi[m]);
        chk($sformatf("s%0d_out_avg", m), m ? avg3 : avg1, m_avg[m]);
        chk($sformatf("s%0d_fill_cnt", m), 32'(m ? fill3 : fill1), 32'(m_fill[m]));
        for (int k = 0; k < 10; k++)
            chk($sformatf("s%0d_net_data_%0d", m, k), m ? nd1[k] : nd0[k], m_win[m][k]);
    endtask

    task automatic cycle(input bit fl, input bit iv, input logic [31:0] id, input bit ordy);
        logic [63:0] e;
        @(negedge clk);
        flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        chk_all(0);
        chk_all(1);
        if (ov1 && ordy) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
            else begin
                e = exp_q.pop_front();
                chk("sb_lo", lo1, e[31:0]);
                chk("sb_hi", hi1, e[63:32]);
            end
        end
        model_step(0, fl, iv, id, ordy);
        model_step(1, fl, iv, id, ordy);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        model_reset();
        chk_all(0);
        chk_all(1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all(0);
        chk_all(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fl, iv, ordy;
        int r;
        logic [31:0] d;

        reset_pulse();
        // Ascending 1..10, then 11, then backpressure with in_valid held.
        for (int i = 1; i <= 10; i++) cycle(0, 1, 32'(i), 1);
        cycle(0, 1, 32'd11, 1);
        chk("eval_in_ready", 32'(rdy1), 32'd0);
        cycle(0, 1, 32'd11, 1);
        chk("first_valid", 32'(ov1), 32'd1);
        chk("first_lo", lo1, 32'd5);
        chk("first_hi", hi1, 32'd6);
        chk("first_avg", avg1, avg_of(32'd5, 32'd6));
        cycle(0, 1, 32'd12, 0);
        chk("eval2_in_ready", 32'(rdy1), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 32'd12, 0);
            chk("bp_lo", lo1, 32'd6);
            chk("bp_hi", hi1, 32'd7);
            chk("bp_in_ready", 32'(rdy1), 32'd0);
        end
        cycle(0, 1, 32'd12, 1);
        chk("dual_in_ready", 32'(rdy1), 32'd1);
        cycle(0, 0, 32'd0, 1);
        chk("dual_fill", 32'(fill1), 32'd10);
        cycle(0, 0, 32'd0, 1);

        // Average near the top of the range.
        reset_pulse();
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'd0, 1);
        cycle(0, 1, 32'hFFFF_FFFD, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'hFFFF_FFFF, 1);
        cycle(0, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 1);
        chk("big_lo", lo1, 32'hFFFF_FFFD);
        chk("big_hi", hi1, 32'hFFFF_FFFF);
`ifdef MEDIAN_AVG_EN
        chk("big_avg", avg1, 32'hFFFF_FFFE);
`else
        chk("big_avg", avg1, 32'd0);
`endif

        // Stride 3: first result after the 12th accept, then flush with in_valid high.
        reset_pulse();
        for (int i = 0; i < 12; i++) cycle(0, 1, 32'(100 + i), 1);
        cycle(0, 0, 32'd0, 1);
        chk("s3_no_early", 32'(ov3), 32'd0);
        cycle(0, 0, 32'd0, 1);
        chk("s3_valid", 32'(ov3), 32'd1);
        cycle(1, 1, 32'd77, 1);
        cycle(0, 0, 32'd0, 1);
        chk("s3_flush_fill", 32'(fill3), 32'd0);
        chk("s3_flush_nd0", nd1[0], 32'd0);

        // Reset while the STRIDE=1 instance sits in EVAL.
        reset_pulse();
        for (int i = 0; i < 10; i++) cycle(0, 1, 32'(i * 7), 1);
        reset_pulse();
        cycle(0, 0, 32'd0, 1);
        cycle(0, 0, 32'd0, 1);
        chk("rst_eval_valid", 32'(ov1), 32'd0);
        chk("rst_eval_fill", 32'(fill1), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 199);
            if (r == 0 || (m_eval[0] && $urandom_range(0, 19) == 0)) begin
                reset_pulse();
            end else begin
                fl   = (r < 4);
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 2))
                    0:       d = 32'($urandom_range(0, 20));
                    1:       d = $urandom;
                    default: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                endcase
                cycle(fl, iv, d, ordy);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
